// File: rtl/iiitb_sipo_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iiitb_sipo_rx : framed LSB-first serial receiver, 1-entry valid/ready buf  |
// | Option macro  : IIITB_SIPO_STOP_CHECK_EN (stop-bit check, frame_err)       |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module iiitb_sipo_rx #(
   parameter int WIDTH = 4
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             serial_in,
   input  logic             frame_n,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             overrun,
   input  logic             overrun_clr,
   output logic             busy,
   output logic             frame_err
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-2:0]   sr_q;
   logic [WIDTH-1:0]   rx_data_q;
   logic               rx_valid_q;
   logic               overrun_q;
   logic               busy_q;

   logic               w_last;
   logic [WIDTH-1:0]   w_word;
   logic               w_pub;
   logic [WIDTH-1:0]   w_pub_word;

   assign w_last = (state_q == S_SHIFT) && (cnt_q == LAST);
   // The incoming bit lands in the MSB; the older bits already sit right-aligned below it.
   assign w_word = {serial_in, sr_q};

`ifdef IIITB_SIPO_STOP_CHECK_EN
   logic [WIDTH-1:0]   hold_q;
   logic               frame_err_q;
   logic               w_stop_err;

   assign w_pub      = (w_last && !frame_n) || ((state_q == S_CHECK) && serial_in);
   assign w_pub_word = (state_q == S_CHECK) ? hold_q : w_word;
   assign w_stop_err = (state_q == S_CHECK) && !serial_in;
   assign frame_err  = frame_err_q;
`else
   assign w_pub      = w_last;
   assign w_pub_word = w_word;
   assign frame_err  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!frame_n) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (!frame_n) begin
               state_d = S_SHIFT;
            end else if (w_last) begin
`ifdef IIITB_SIPO_STOP_CHECK_EN
               state_d = S_CHECK;
`else
               state_d = S_IDLE;
`endif
            end
         end
`ifdef IIITB_SIPO_STOP_CHECK_EN
         S_CHECK: begin
            state_d = frame_n ? S_IDLE : S_SHIFT;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         sr_q       <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         busy_q     <= 1'b0;
`ifdef IIITB_SIPO_STOP_CHECK_EN
         hold_q      <= '0;
         frame_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != S_IDLE);

         if (state_q == S_SHIFT) begin
            // A low frame_n before the last bit is the T0 of a new frame, so no sample is taken.
            cnt_q <= (w_last || !frame_n) ? '0 : cnt_q + CW'(1);
            if (w_last || frame_n) sr_q <= w_word[WIDTH-1:1];
         end else begin
            cnt_q <= '0;
         end

`ifdef IIITB_SIPO_STOP_CHECK_EN
         if (w_last) hold_q <= w_word;
         if (w_stop_err) frame_err_q <= 1'b1;
`endif

         if (w_pub) begin
            if (!(rx_valid_q && !rx_ready)) begin
               rx_data_q  <= w_pub_word;
               rx_valid_q <= 1'b1;
            end
         end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end

         if (overrun_clr) overrun_q <= 1'b0;
         if (w_pub && rx_valid_q && !rx_ready) overrun_q <= 1'b1;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign overrun  = overrun_q;
   assign busy     = busy_q;

endmodule
`default_nettype wire
